// File: rtl/health_if.sv
// Hit request handshake between an attack source and the health manager.
// The source drives the request fields and holds hit_valid until hit_ack.
interface health_if;
  logic       hit_valid;
  logic [4:0] hit_damage;
  logic       hit_blocked;
  logic       hit_ack;
  logic       hit_landed;

  modport master (
    output hit_valid, hit_damage, hit_blocked,
    input  hit_ack, hit_landed
  );

  modport slave (
    input  hit_valid, hit_damage, hit_blocked,
    output hit_ack, hit_landed
  );
endinterface

// File: rtl/health_manager.sv
// Fighter health tracker: applies hit damage, manages invulnerability frames
// after a clean hit, and latches KO until the next round_start.
module health_manager #(
  parameter int FULL_HEALTH  = 31,
  parameter int INVULN_TICKS = 8,
  parameter int BLOCK_SHIFT  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       round_start,
  input  logic       tick_en,
  health_if.slave    hit,
  output logic [4:0] curr_health,
  output logic       invuln,
  output logic       ko
);

  localparam logic [4:0] FULL  = 5'(FULL_HEALTH);
  localparam logic [7:0] TICKS = 8'(INVULN_TICKS);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    KO     = 2'd2
  } state_t;

  function automatic logic [4:0] eff_damage(input logic [4:0] dmg, input logic blocked);
    return blocked ? (dmg >> BLOCK_SHIFT) : dmg;
  endfunction

  // Chip damage saturates at 1 so a blocked hit can never finish the fighter.
  function automatic logic [4:0] chip_sat(input logic [4:0] h, input logic [4:0] eff);
    return (eff >= h) ? 5'd1 : (h - eff);
  endfunction

  state_t     state_p1, state_p0;
  logic [4:0] health_p1, health_p0;
  logic [7:0] cnt_p1, cnt_p0;
  logic       ack_p1, ack_p0;
  logic       landed_p1, landed_p0;

  logic       accept_p0;
  logic [4:0] eff_p0;
  logic [4:0] chip_p0;

  always_comb begin
    accept_p0 = hit.hit_valid && !ack_p1;
    eff_p0    = eff_damage(hit.hit_damage, hit.hit_blocked);
    chip_p0   = chip_sat(health_p1, eff_p0);

    state_p0  = state_p1;
    health_p0 = health_p1;
    cnt_p0    = cnt_p1;
    ack_p0    = accept_p0;
    landed_p0 = 1'b0;

    // round_start overrides everything; a coincident hit is only acked.
    if (round_start) begin
      state_p0  = ALIVE;
      health_p0 = FULL;
      cnt_p0    = 8'd0;
    end else begin
      case (state_p1)
        ALIVE: begin
          if (accept_p0 && (eff_p0 != 5'd0)) begin
            if (hit.hit_blocked) begin
              health_p0 = chip_p0;
              landed_p0 = (chip_p0 != health_p1);
            end else if (eff_p0 >= health_p1) begin
              health_p0 = 5'd0;
              state_p0  = KO;
              landed_p0 = 1'b1;
            end else begin
              health_p0 = health_p1 - eff_p0;
              state_p0  = INVULN;
              cnt_p0    = TICKS;
              landed_p0 = 1'b1;
            end
          end
        end
        INVULN: begin
          if (tick_en) begin
            if (cnt_p1 <= 8'd1) begin
              state_p0 = ALIVE;
              cnt_p0   = 8'd0;
            end else begin
              cnt_p0 = cnt_p1 - 8'd1;
            end
          end
        end
        KO: begin
          health_p0 = 5'd0;
        end
        default: begin
          state_p0 = ALIVE;
          cnt_p0   = 8'd0;
        end
      endcase
    end
  end

  // ---- registered stage p1 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1  <= ALIVE;
      health_p1 <= FULL;
      cnt_p1    <= 8'd0;
      ack_p1    <= 1'b0;
      landed_p1 <= 1'b0;
    end else begin
      state_p1  <= state_p0;
      health_p1 <= health_p0;
      cnt_p1    <= cnt_p0;
      ack_p1    <= ack_p0;
      landed_p1 <= landed_p0;
    end
  end

  assign curr_health    = health_p1;
  assign invuln         = (state_p1 == INVULN);
  assign ko             = (state_p1 == KO);
  assign hit.hit_ack    = ack_p1;
  assign hit.hit_landed = landed_p1;

  a_ack_single:   assert property (@(posedge clk) disable iff (!rst_n) ack_p1 |=> !ack_p1);
  a_landed_ack:   assert property (@(posedge clk) disable iff (!rst_n) landed_p1 |-> ack_p1);
  a_state_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(invuln && ko));
  a_health_max:   assert property (@(posedge clk) disable iff (!rst_n) health_p1 <= FULL);

endmodule

// File: tb/tb_health_manager.sv
// Directed bench for health_manager: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_health_manager;

  logic       clk;
  logic       rst_n;
  logic       round_start;
  logic       tick_en;
  logic [4:0] curr_health;
  logic       invuln;
  logic       ko;

  health_if hif ();

  health_manager #(
    .FULL_HEALTH (31),
    .INVULN_TICKS(8),
    .BLOCK_SHIFT (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .round_start(round_start),
    .tick_en    (tick_en),
    .hit        (hif),
    .curr_health(curr_health),
    .invuln     (invuln),
    .ko         (ko)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic got_ack;
  logic got_landed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one hit for exactly one accept cycle; captures the response.
  task automatic do_hit(input logic [4:0] dmg, input logic blk);
    @(posedge clk);
    @(negedge clk);
    hif.hit_valid   = 1'b1;
    hif.hit_damage  = dmg;
    hif.hit_blocked = blk;
    @(posedge clk); #1;
    got_ack         = hif.hit_ack;
    got_landed      = hif.hit_landed;
    hif.hit_valid   = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      tick_en = 1'b1;
      @(posedge clk); #1;
      tick_en = 1'b0;
    end
  endtask

  task automatic pulse_round;
    @(negedge clk);
    round_start = 1'b1;
    @(posedge clk); #1;
    round_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (curr_health !== 5'd31) begin tests_failed++; $display("FAIL reset_health got %0d want 31", curr_health); end
    tests_run++;
    if ({hif.hit_ack, hif.hit_landed, invuln, ko} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_flags got ack=%b landed=%b invuln=%b ko=%b want 0000", hif.hit_ack, hif.hit_landed, invuln, ko);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unblocked_hit;
    do_hit(5'd10, 1'b0);
    tests_run++;
    if ({got_ack, got_landed, invuln} !== 3'b111) begin
      tests_failed++; $display("FAIL unblocked_flags got ack=%b landed=%b invuln=%b want 111", got_ack, got_landed, invuln);
    end
    tests_run++;
    if (curr_health !== 5'd21) begin tests_failed++; $display("FAIL unblocked_health got %0d want 21", curr_health); end
  endtask

  task automatic test_invuln;
    do_hit(5'd5, 1'b0);
    tests_run++;
    if ({got_ack, got_landed} !== 2'b10 || curr_health !== 5'd21) begin
      tests_failed++; $display("FAIL invuln_discard got ack=%b landed=%b health=%0d want ack=1 landed=0 health=21", got_ack, got_landed, curr_health);
    end
    do_ticks(7);
    tests_run++;
    if (invuln !== 1'b1) begin tests_failed++; $display("FAIL invuln_7ticks got %b want 1", invuln); end
    do_ticks(1);
    tests_run++;
    if (invuln !== 1'b0) begin tests_failed++; $display("FAIL invuln_8ticks got %b want 0", invuln); end
  endtask

  task automatic test_chip_damage;
    do_hit(5'd18, 1'b0);
    tests_run++;
    if (curr_health !== 5'd3) begin tests_failed++; $display("FAIL chip_setup got %0d want 3", curr_health); end
    do_ticks(8);
    do_hit(5'd20, 1'b1);
    tests_run++;
    if (curr_health !== 5'd1 || ko !== 1'b0 || invuln !== 1'b0 || got_landed !== 1'b1) begin
      tests_failed++; $display("FAIL chip_first got health=%0d ko=%b invuln=%b landed=%b want 1 0 0 1", curr_health, ko, invuln, got_landed);
    end
    do_hit(5'd20, 1'b1);
    tests_run++;
    if ({got_ack, got_landed} !== 2'b10 || curr_health !== 5'd1) begin
      tests_failed++; $display("FAIL chip_second got ack=%b landed=%b health=%0d want 1 0 1", got_ack, got_landed, curr_health);
    end
    do_hit(5'd3, 1'b1);
    tests_run++;
    if ({got_ack, got_landed, invuln, ko} !== 4'b1000 || curr_health !== 5'd1) begin
      tests_failed++; $display("FAIL zero_eff got ack=%b landed=%b invuln=%b ko=%b health=%0d want 1000 1", got_ack, got_landed, invuln, ko, curr_health);
    end
  endtask

  task automatic test_ko;
    pulse_round;
    tests_run++;
    if (curr_health !== 5'd31) begin tests_failed++; $display("FAIL round_restore got %0d want 31", curr_health); end
    do_hit(5'd27, 1'b0);
    do_ticks(8);
    tests_run++;
    if (curr_health !== 5'd4 || invuln !== 1'b0) begin
      tests_failed++; $display("FAIL ko_setup got health=%0d invuln=%b want 4 0", curr_health, invuln);
    end
    do_hit(5'd4, 1'b0);
    tests_run++;
    if (curr_health !== 5'd0 || ko !== 1'b1 || got_landed !== 1'b1) begin
      tests_failed++; $display("FAIL ko_enter got health=%0d ko=%b landed=%b want 0 1 1", curr_health, ko, got_landed);
    end
    do_hit(5'd10, 1'b0);
    tests_run++;
    if ({got_ack, got_landed} !== 2'b10 || curr_health !== 5'd0) begin
      tests_failed++; $display("FAIL ko_discard got ack=%b landed=%b health=%0d want 1 0 0", got_ack, got_landed, curr_health);
    end
    do_ticks(2);
    tests_run++;
    if (ko !== 1'b1 || curr_health !== 5'd0) begin
      tests_failed++; $display("FAIL ko_ticks got ko=%b health=%0d want 1 0", ko, curr_health);
    end
  endtask

  task automatic test_round_with_hit;
    @(posedge clk);
    @(negedge clk);
    round_start     = 1'b1;
    hif.hit_valid   = 1'b1;
    hif.hit_damage  = 5'd10;
    hif.hit_blocked = 1'b0;
    @(posedge clk); #1;
    round_start     = 1'b0;
    hif.hit_valid   = 1'b0;
    tests_run++;
    if (curr_health !== 5'd31 || ko !== 1'b0 || hif.hit_ack !== 1'b1 || hif.hit_landed !== 1'b0) begin
      tests_failed++; $display("FAIL round_hit got health=%0d ko=%b ack=%b landed=%b want 31 0 1 0", curr_health, ko, hif.hit_ack, hif.hit_landed);
    end
  endtask

  task automatic test_final_tick_hit;
    do_hit(5'd1, 1'b0);
    do_ticks(7);
    @(negedge clk);
    tick_en         = 1'b1;
    hif.hit_valid   = 1'b1;
    hif.hit_damage  = 5'd10;
    hif.hit_blocked = 1'b0;
    @(posedge clk); #1;
    tick_en         = 1'b0;
    hif.hit_valid   = 1'b0;
    tests_run++;
    if (invuln !== 1'b0 || hif.hit_ack !== 1'b1 || hif.hit_landed !== 1'b0 || curr_health !== 5'd30) begin
      tests_failed++; $display("FAIL final_tick_hit got invuln=%b ack=%b landed=%b health=%0d want 0 1 0 30", invuln, hif.hit_ack, hif.hit_landed, curr_health);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] acks;
    int landed_cnt;
    landed_cnt = 0;
    acks = 5'd0;
    @(posedge clk);
    @(negedge clk);
    hif.hit_valid   = 1'b1;
    hif.hit_damage  = 5'd2;
    hif.hit_blocked = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      acks[i] = hif.hit_ack;
      if (hif.hit_landed === 1'b1) landed_cnt++;
    end
    hif.hit_valid = 1'b0;
    tests_run++;
    if (acks !== 5'b10101) begin tests_failed++; $display("FAIL held_ack_pattern got %b want 10101", acks); end
    tests_run++;
    if (landed_cnt !== 1 || curr_health !== 5'd28) begin
      tests_failed++; $display("FAIL held_single_apply got landed=%0d health=%0d want 1 28", landed_cnt, curr_health);
    end
  endtask

  task automatic test_reset_mid_handshake;
    @(posedge clk);
    @(negedge clk);
    hif.hit_valid   = 1'b1;
    hif.hit_damage  = 5'd2;
    hif.hit_blocked = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (hif.hit_ack !== 1'b1) begin tests_failed++; $display("FAIL mid_ack got %b want 1", hif.hit_ack); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (hif.hit_ack !== 1'b0 || curr_health !== 5'd31 || invuln !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset got ack=%b health=%0d invuln=%b want 0 31 0", hif.hit_ack, curr_health, invuln);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    hif.hit_valid = 1'b0;
    tests_run++;
    if (hif.hit_ack !== 1'b1 || hif.hit_landed !== 1'b1 || curr_health !== 5'd29) begin
      tests_failed++; $display("FAIL post_reset_hit got ack=%b landed=%b health=%0d want 1 1 29", hif.hit_ack, hif.hit_landed, curr_health);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    round_start     = 1'b0;
    tick_en         = 1'b0;
    hif.hit_valid   = 1'b0;
    hif.hit_damage  = 5'd0;
    hif.hit_blocked = 1'b0;

    test_reset;
    test_unblocked_hit;
    test_invuln;
    test_chip_damage;
    test_ko;
    test_round_with_hit;
    test_final_tick_hit;
    test_back_to_back;
    test_reset_mid_handshake;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/health_manager.md
HEALTH_MANAGER -- requirements
Module: health_manager

Interface
- REQ-001 Parameter FULL_HEALTH, default 31: health loaded at reset and at round_start. Must be at most 31.
- REQ-002 Parameter INVULN_TICKS, default 8: invulnerability length in tick_en pulses. Range 1..255.
- REQ-003 Parameter BLOCK_SHIFT, default 2: right-shift applied to damage on a blocked hit.
- REQ-004 clk, input, 1: single system clock; all state changes on its rising edge.
- REQ-005 rst_n, input, 1: asynchronous, active-low reset.
- REQ-006 round_start, input, 1: one-cycle pulse that restores full health and leaves KO.
- REQ-007 tick_en, input, 1: one-cycle frame tick that paces the invulnerability countdown.
- REQ-008 hit_valid, input, 1: hit request; held high by the source until hit_ack.
- REQ-009 hit_damage, input, 5: raw damage; sampled while hit_valid=1.
- REQ-010 hit_blocked, input, 1: defender is blocking; sampled with hit_damage.
- REQ-011 curr_health, output, 5: registered health value; feeds the health-bar renderer.
- REQ-012 hit_ack, output, 1: one-cycle pulse acknowledging one hit request.
- REQ-013 hit_landed, output, 1: one-cycle pulse, coincident with hit_ack, when health changed.
- REQ-014 invuln, output, 1: high while in state INVULN.
- REQ-015 ko, output, 1: high while in state KO.

Function
- REQ-016 States are ALIVE, INVULN and KO; the state is held in registers; invuln and ko are decoded from the state.
- REQ-017 A hit is accepted in a cycle where hit_valid=1 and hit_ack=0. The response is registered: hit_ack=1 on the next cycle. A request still high during hit_ack is not re-accepted.
- REQ-018 Every accepted hit produces exactly one hit_ack, in every state.
- REQ-019 Effective damage is 5-bit: hit_damage when hit_blocked=0; hit_damage>>BLOCK_SHIFT (truncating) when hit_blocked=1.
- REQ-020 ALIVE, unblocked hit, eff >= curr_health: curr_health becomes 0, the state goes to KO, and hit_landed pulses.
- REQ-021 ALIVE, unblocked hit, 0 < eff < curr_health: curr_health decreases by eff, the state goes to INVULN, the counter loads INVULN_TICKS, and hit_landed pulses.
- REQ-022 ALIVE, blocked hit, eff > 0: curr_health becomes max(curr_health-eff, 1); hit_landed pulses only if the value changed; the state stays ALIVE. Chip damage never causes KO.
- REQ-023 An accepted hit with eff=0: acked only, with no health change, no hit_landed and no state change.
- REQ-024 INVULN: accepted hits are acked and discarded; no hit_landed.
- REQ-025 INVULN: each tick_en decrements the 8-bit counter. A tick_en while the counter=1 returns the state to ALIVE on the next edge.
- REQ-026 KO: accepted hits are acked and discarded; curr_health holds at 0; tick_en is ignored.
- REQ-027 round_start=1 from any state loads curr_health=FULL_HEALTH, the state ALIVE and the counter 0. It wins over a hit accepted in the same cycle: that hit is still acked but has no effect and no hit_landed.
- REQ-028 A hit accepted in the same cycle as the final tick_en of INVULN is evaluated in INVULN, so it is discarded.
- REQ-029 curr_health never wraps below 0 and never exceeds FULL_HEALTH.

Reset
- REQ-030 While rst_n=0, and asynchronously on its assertion:
  - curr_health=FULL_HEALTH, state ALIVE, counter 0;
  - hit_ack=0, hit_landed=0, invuln=0, ko=0.
- REQ-031 Reset asserted mid-handshake drops the pending hit. After release, a still-high hit_valid is treated as a new request.

Verification
- REQ-032 Reset, then unblocked hit_damage=10 → next cycle: hit_ack=1, hit_landed=1, curr_health=21, invuln=1.
- REQ-033 During INVULN, hit_damage=5 → hit_ack=1, hit_landed=0, curr_health=21. After 8 tick_en pulses → invuln=0.
- REQ-034 curr_health=3, blocked hit_damage=20 (eff=5) → curr_health=1, ko=0. A second identical blocked hit → hit_ack=1, hit_landed=0, curr_health=1.
- REQ-035 curr_health=4, unblocked hit_damage=4 → curr_health=0, ko=1. Further hits → acked, curr_health=0.
- REQ-036 In KO, round_start and hit_valid in the same cycle → curr_health=31, ko=0, hit_ack=1, hit_landed=0.
- REQ-037 hit_valid held high for 5 cycles → exactly one damage application; the held request is acked on alternate cycles, and each ack after the first is handled per REQ-024/026.
